frame_demap: RTL

Receive-side counterpart of the sender map/data-request path. It consumes the deframed line byte stream and tracks row and column position within each frame. It routes the 16 overhead bytes per row to the overhead output and the 1024 payload bytes per row to the payload FIFO, and discards the end-of-row pad column. It flags misalignment and payload drops, and pulses a retransmission request at the end of any frame that lost payload.

---
 rtl/frame_demap.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/frame_demap.sv
// frame_demap: receive-side frame demapper.
// Tracks row/column within each frame of the deframed line byte stream.
// Overhead columns go to the overhead port, payload columns go to the
// payload FIFO, and the trailing pad column of every row is discarded.
// Lost payload is remembered per frame and reported as a retransmission
// request alongside the end-of-frame pulse.
module frame_demap #(
    parameter int COLS    = 1041,
    parameter int OH_COLS = 16,
    parameter int ROWS    = 4,
    parameter int DW      = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_line_data,
    input  logic          i_line_valid,
    input  logic          i_sof,
    input  logic          i_pyld_fifo_ready,
    output logic [DW-1:0] o_pyld_data,
    output logic          o_pyld_valid,
    output logic [DW-1:0] o_oh_data,
    output logic          o_oh_valid,
    output logic [3:0]    o_oh_idx,
    output logic [1:0]    o_row_cnt,
    output logic [10:0]   o_col_cnt,
    output logic          o_in_frame,
    output logic          o_frame_done,
    output logic          o_retrans_req,
    output logic          o_align_err
);

    // Frame tracking states
    localparam logic ST_HUNT  = 1'b0;
    localparam logic ST_FRAME = 1'b1;

    // Column/row landmarks in the counter widths
    localparam logic [10:0] OH_END   = 11'(OH_COLS);
    localparam logic [10:0] LAST_COL = 11'(COLS - 1);
    localparam logic [1:0]  LAST_ROW = 2'(ROWS - 1);

    // Registered frame position and status
    logic        state;
    logic [1:0]  row;
    logic [10:0] col;
    logic        drop;

    // Next-state values
    logic        state_n;
    logic [1:0]  row_n;
    logic [10:0] col_n;
    logic        drop_n;

    // Byte classification at the current position
    logic is_oh;
    logic is_pad;
    logic is_pyld;
    logic is_last;

    // Input qualification
    logic restart;
    logic take;
    logic in_frame;

    // Classify the current column and qualify the incoming byte
    always_comb begin
        in_frame = (state == ST_FRAME);
        is_oh    = (col < OH_END);
        is_pad   = (col == LAST_COL);
        is_pyld  = !is_oh && !is_pad;
        is_last  = is_pad && (row == LAST_ROW);
        // A valid sof always forces row 0 col 0, in HUNT or mid-frame.
        restart  = i_line_valid && i_sof;
        take     = i_line_valid && !i_sof && in_frame;
    end

    // Compute next state, position and drop flag
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        drop_n  = drop;
        if (restart) begin
            state_n = ST_FRAME;
            row_n   = '0;
            col_n   = 11'd1;
            drop_n  = 1'b0;
        end else if (take) begin
            if (is_pyld && !i_pyld_fifo_ready) begin
                drop_n = 1'b1;
            end
            if (is_last) begin
                state_n = ST_HUNT;
                row_n   = '0;
                col_n   = '0;
            end else if (is_pad) begin
                row_n = row + 2'd1;
                col_n = '0;
            end else begin
                col_n = col + 11'd1;
            end
        end
    end

    // Register state, position and drop flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_HUNT;
            row   <= '0;
            col   <= '0;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            col   <= col_n;
            drop  <= drop_n;
        end
    end

    // Register overhead port for overhead columns and restarts
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_oh_valid <= 1'b0;
            o_oh_data  <= '0;
            o_oh_idx   <= '0;
        end else begin
            o_oh_valid <= 1'b0;
            if (restart) begin
                o_oh_valid <= 1'b1;
                o_oh_data  <= i_line_data;
                o_oh_idx   <= '0;
            end else if (take && is_oh) begin
                o_oh_valid <= 1'b1;
                o_oh_data  <= i_line_data;
                o_oh_idx   <= col[3:0];
            end
        end
    end

    // Register payload FIFO write when the FIFO can take the byte
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pyld_valid <= 1'b0;
            o_pyld_data  <= '0;
        end else begin
            o_pyld_valid <= 1'b0;
            if (take && is_pyld && i_pyld_fifo_ready) begin
                o_pyld_valid <= 1'b1;
                o_pyld_data  <= i_line_data;
            end
        end
    end

    // Register end-of-frame, retransmission and alignment pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_done  <= 1'b0;
            o_retrans_req <= 1'b0;
            o_align_err   <= 1'b0;
        end else begin
            o_frame_done  <= 1'b0;
            o_retrans_req <= 1'b0;
            o_align_err   <= restart && in_frame;
            // The last byte is a pad byte, so the registered flag is final.
            if (take && is_last) begin
                o_frame_done  <= 1'b1;
                o_retrans_req <= drop;
            end
        end
    end

    assign o_row_cnt  = row;
    assign o_col_cnt  = col;
    assign o_in_frame = in_frame;

endmodule
